// File: rtl/proto_field_encoder_pkg.sv
// rtl/proto_field_encoder_pkg.sv - shared constants, wire types and encoder state for the field encoder
package proto_field_encoder_pkg;

    localparam int IDENTIFIER_SIZE = 4;
    localparam int VALUE_WIDTH     = 64;
    localparam int KEY_SIZE        = IDENTIFIER_SIZE + 3;

    typedef logic [2:0] wire_type_t;

    localparam wire_type_t WT_VARINT  = 3'd0;
    localparam wire_type_t WT_FIXED64 = 3'd1;
    localparam wire_type_t WT_LEN     = 3'd2;
    localparam wire_type_t WT_FIXED32 = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_KEY,
        ST_VALUE
    } enc_state_t;

    function automatic logic wt_supported(input wire_type_t wt);
        return (wt == WT_VARINT) || (wt == WT_FIXED64) ||
               (wt == WT_LEN)    || (wt == WT_FIXED32);
    endfunction

    // Varint and length values both go through the varint emitter
    function automatic logic wt_is_varint(input wire_type_t wt);
        return (wt == WT_VARINT) || (wt == WT_LEN);
    endfunction

endpackage

// File: rtl/proto_field_encoder_varint.sv
// rtl/proto_field_encoder_varint.sv - varint emitter: 7-bit groups with continuation bit under valid/ready
module proto_varint_emitter
    import proto_field_encoder_pkg::*;
#(
    parameter int VALUE_WIDTH = proto_field_encoder_pkg::VALUE_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [VALUE_WIDTH-1:0] load_value,
    input  logic                   byte_ready,
    output logic                   byte_valid,
    output logic [7:0]             byte_data,
    output logic                   byte_final
);

    logic [VALUE_WIDTH-1:0] shreg;

    // Termination is by value: the byte is final once nothing remains above bit 6
    assign byte_final = ~|shreg[VALUE_WIDTH-1:7];
    assign byte_data  = {~byte_final, shreg[6:0]};

    // Load a new value (wins over an advance) or drop the accepted 7-bit group
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg      <= '0;
            byte_valid <= 1'b0;
        end else if (load) begin
            shreg      <= load_value;
            byte_valid <= 1'b1;
        end else if (byte_valid && byte_ready) begin
            shreg <= shreg >> 7;
            if (byte_final) begin
                byte_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/proto_field_encoder.sv
// rtl/proto_field_encoder.sv - serializes field descriptors into protobuf wire-format bytes
module proto_field_encoder
    import proto_field_encoder_pkg::*;
#(
    parameter int IDENTIFIER_SIZE = proto_field_encoder_pkg::IDENTIFIER_SIZE,
    parameter int VALUE_WIDTH     = proto_field_encoder_pkg::VALUE_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [IDENTIFIER_SIZE-1:0] in_field_id,
    input  logic [2:0]                 in_wire_type,
    input  logic [VALUE_WIDTH-1:0]     in_value,
    input  logic                       in_raw,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [7:0]                 out_data,
    output logic                       out_last,
    output logic                       err
);

    localparam int KEY_W = IDENTIFIER_SIZE + 3;

    enc_state_t state, state_next;

    wire_type_t             lat_wt;
    logic [VALUE_WIDTH-1:0] lat_value;
    logic                   lat_last;

    // Fixed-width little-endian path; raw bytes reuse it with a count of 1
    logic                   use_fix;
    logic [VALUE_WIDTH-1:0] fix_shreg;
    logic [3:0]             fix_cnt;

    logic                   vint_load;
    logic [VALUE_WIDTH-1:0] vint_load_value;
    logic                   vint_advance;
    logic                   vint_valid;
    logic [7:0]             vint_data;
    logic                   vint_final;

    logic accept;
    logic xfer;
    logic cur_final;
    logic key_done;

    proto_varint_emitter #(
        .VALUE_WIDTH(VALUE_WIDTH)
    ) u_varint (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (vint_load),
        .load_value(vint_load_value),
        .byte_ready(vint_advance),
        .byte_valid(vint_valid),
        .byte_data (vint_data),
        .byte_final(vint_final)
    );

    assign in_ready  = (state == ST_IDLE);
    assign accept    = in_valid && in_ready;
    assign out_valid = use_fix ? (fix_cnt != 4'd0) : vint_valid;
    assign out_data  = use_fix ? fix_shreg[7:0] : vint_data;
    assign xfer      = out_valid && out_ready;
    assign cur_final = use_fix ? (fix_cnt == 4'd1) : vint_final;
    assign key_done  = (state == ST_KEY) && xfer && vint_final;
    assign out_last  = (state == ST_VALUE) && out_valid && cur_final && lat_last;

    // State register; reset drops any partial field
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: key first, then value, back to idle after the last value byte
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    if (in_raw) begin
                        state_next = ST_VALUE;
                    end else if (wt_supported(in_wire_type)) begin
                        state_next = ST_KEY;
                    end
                end
            end
            ST_KEY: begin
                if (key_done) begin
                    state_next = ST_VALUE;
                end
            end
            ST_VALUE: begin
                if (xfer && cur_final) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Varint emitter control: key on accept, value/length right after the last key byte
    always_comb begin
        vint_load       = 1'b0;
        vint_load_value = '0;
        if (accept && !in_raw && wt_supported(in_wire_type)) begin
            vint_load       = 1'b1;
            vint_load_value = {{(VALUE_WIDTH-KEY_W){1'b0}}, in_field_id, in_wire_type};
        end else if (key_done && wt_is_varint(lat_wt)) begin
            vint_load       = 1'b1;
            vint_load_value = lat_value;
        end
        vint_advance = xfer && !use_fix;
    end

    // Descriptor latch, fixed/raw byte path and error pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lat_wt    <= WT_VARINT;
            lat_value <= '0;
            lat_last  <= 1'b0;
            use_fix   <= 1'b0;
            fix_shreg <= '0;
            fix_cnt   <= 4'd0;
            err       <= 1'b0;
        end else begin
            err <= accept && !in_raw && !wt_supported(in_wire_type);
            if (accept) begin
                lat_wt    <= in_wire_type;
                lat_value <= in_value;
                lat_last  <= in_last;
                if (in_raw) begin
                    use_fix   <= 1'b1;
                    fix_shreg <= {{(VALUE_WIDTH-8){1'b0}}, in_value[7:0]};
                    fix_cnt   <= 4'd1;
                end else begin
                    use_fix <= 1'b0;
                end
            end else if (key_done && !wt_is_varint(lat_wt)) begin
                use_fix <= 1'b1;
                if (lat_wt == WT_FIXED32) begin
                    fix_shreg <= {{(VALUE_WIDTH-32){1'b0}}, lat_value[31:0]};
                    fix_cnt   <= 4'd4;
                end else begin
                    fix_shreg <= lat_value;
                    fix_cnt   <= 4'd8;
                end
            end else if ((state == ST_VALUE) && use_fix && xfer) begin
                fix_shreg <= {8'h00, fix_shreg[VALUE_WIDTH-1:8]};
                fix_cnt   <= fix_cnt - 4'd1;
            end
        end
    end

endmodule
